// File: rtl/sync_fifo_flags_if.sv
// Handshake/status bundle for sync_fifo_flags: host drives requests (master),
// the FIFO drives data and flags (slave).
interface sync_fifo_flags_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  write_req;
  logic                  read_req;
  logic                  flush;
  logic                  clear_err;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write_req, read_req, flush, clear_err, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  write_req, read_req, flush, clear_err, data_in,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky
// overflow/underflow and synchronous flush. Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flags #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2
) (
  input  logic clk,
  input  logic reset,
  sync_fifo_flags_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  ovf;
  logic                  unf;
  logic                  is_full;
  logic                  is_empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_set;
  logic                  unf_set;

  assign is_full  = (cnt == DEPTH_C);
  assign is_empty = (cnt == '0);

  // Flush masks both requests so neither moves state nor raises an error.
  always_comb begin
    wr_acc  = bus.write_req & (~is_full | bus.read_req) & ~bus.flush;
    rd_acc  = bus.read_req & ~is_empty & ~bus.flush;
    ovf_set = bus.write_req & is_full & ~bus.read_req & ~bus.flush;
    unf_set = bus.read_req & is_empty & ~bus.flush;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dout_q <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        case ({wr_acc, rd_acc})
          2'b10:   cnt <= cnt + (ADDR_WIDTH + 1)'(1);
          2'b01:   cnt <= cnt - (ADDR_WIDTH + 1)'(1);
          default: cnt <= cnt;
        endcase
      end
      if (rd_acc) dout_q <= mem[rd_ptr];
      // Set wins over a same-cycle clear.
      ovf <= ovf_set | (ovf & ~bus.clear_err);
      unf <= unf_set | (unf & ~bus.clear_err);
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word shown live; dout_q keeps the last popped word for the empty case.
  assign bus.data_out = is_empty ? dout_q : mem[rd_ptr];
`else
  assign bus.data_out = dout_q;
`endif

  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (cnt >= AF_C);
  assign bus.almost_empty = (cnt <= AE_C);
  assign bus.count        = cnt;
  assign bus.overflow     = ovf;
  assign bus.underflow    = unf;
endmodule
